// File: rtl/sha256_w_sched_iter_ctrl.sv
// rtl/sha256_w_sched_iter_ctrl.sv - iterative SHA-256 message schedule streamer
// Optional: W15_CONST_EN forces W14/W15 to the 640-bit double-SHA length padding.
module sha256_w_sched_iter_ctrl #(
    parameter int NUM_WORDS = 64,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_in,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_word,
    output logic [5:0]       w_idx,
    output logic             w_last,
    output logic             done,
    output logic [CNT_W-1:0] job_cnt
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);
    localparam logic [6:0] NUM_W7   = 7'(NUM_WORDS);

    state_t            state_q, state_d;
    logic [31:0]       window_q [16];
    logic [31:0]       window_d [16];
    logic [5:0]        t_q, t_d;
    logic              w_valid_q, w_valid_d;
    logic              w_last_q, w_last_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  job_cnt_q, job_cnt_d;
    logic [31:0]       s0_term;
    logic [31:0]       next_w;
    logic              hs;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

`ifdef W15_CONST_EN
    // At t==14 window[1] holds the forced W15 = 0x280, whose sigma0 is fixed.
    assign s0_term = (t_q == 6'd14) ? 32'h00A00055 : sig0(window_q[1]);
`else
    assign s0_term = sig0(window_q[1]);
`endif

    assign next_w = ((7'({1'b0, t_q}) + 7'd16) < NUM_W7)
                  ? sig1(window_q[14]) + window_q[9] + s0_term + window_q[0]
                  : 32'd0;

    assign hs        = w_valid_q && w_ready;
    assign blk_ready = (state_q == IDLE) && !flush && !RST;

    always_comb begin
        state_d   = state_q;
        window_d  = window_q;
        t_d       = t_q;
        w_valid_d = w_valid_q;
        w_last_d  = w_last_q;
        done_d    = 1'b0;
        job_cnt_d = job_cnt_q;
        if (flush) begin
            state_d   = IDLE;
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
        end else if (state_q == IDLE) begin
            if (blk_valid) begin
                for (int i = 0; i < 16; i++) begin
                    window_d[i] = blk_in[511 - 32*i -: 32];
                end
`ifdef W15_CONST_EN
                window_d[14] = 32'h00000000;
                window_d[15] = 32'h00000280;
`endif
                t_d       = 6'd0;
                w_valid_d = 1'b1;
                w_last_d  = 1'b0;
                state_d   = STREAM;
            end
        end else if (hs) begin
            if (t_q == LAST_IDX) begin
                state_d   = IDLE;
                w_valid_d = 1'b0;
                w_last_d  = 1'b0;
                done_d    = 1'b1;
                job_cnt_d = job_cnt_q + 1'b1;
            end else begin
                for (int i = 0; i < 15; i++) begin
                    window_d[i] = window_q[i+1];
                end
                window_d[15] = next_w;
                t_d          = t_q + 6'd1;
                w_last_d     = ((t_q + 6'd1) == LAST_IDX);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            for (int i = 0; i < 16; i++) begin
                window_q[i] <= 32'd0;
            end
            t_q       <= 6'd0;
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            done_q    <= 1'b0;
            job_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            window_q  <= window_d;
            t_q       <= t_d;
            w_valid_q <= w_valid_d;
            w_last_q  <= w_last_d;
            done_q    <= done_d;
            job_cnt_q <= job_cnt_d;
        end
    end

    assign w_valid = w_valid_q;
    assign w_word  = window_q[0];
    assign w_idx   = t_q;
    assign w_last  = w_last_q;
    assign done    = done_q;
    assign job_cnt = job_cnt_q;

endmodule

// File: tb/tb_sha256_w_sched_iter_ctrl.sv
// tb/tb_sha256_w_sched_iter_ctrl.sv - randomized model-checked bench for the schedule streamer
module tb_sha256_w_sched_iter_ctrl;

    localparam int N     = 64;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic             flush;
    logic             blk_valid;
    logic             blk_ready;
    logic [511:0]     blk_in;
    logic             w_valid;
    logic             w_ready = 1'b1;
    logic [31:0]      w_word;
    logic [5:0]       w_idx;
    logic             w_last;
    logic             done;
    logic [CNT_W-1:0] job_cnt;

    sha256_w_sched_iter_ctrl #(.NUM_WORDS(N), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_in(blk_in),
        .w_valid(w_valid), .w_ready(w_ready), .w_word(w_word),
        .w_idx(w_idx), .w_last(w_last), .done(done), .job_cnt(job_cnt)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    logic rand_ready = 1'b0;
    logic mon_en = 1'b0;

    // reference model state
    logic [31:0]      exp_w [0:63];
    logic [31:0]      cap   [0:63];
    logic             m_active = 1'b0;
    logic             m_done = 1'b0;
    logic             m_zero = 1'b1;
    int               m_idx = 0;
    logic [CNT_W-1:0] m_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build(input logic [511:0] b);
        for (int i = 0; i < 16; i++) exp_w[i] = b[511 - 32*i -: 32];
`ifdef W15_CONST_EN
        exp_w[14] = 32'h0;
        exp_w[15] = 32'h280;
`endif
        for (int t = 16; t < 64; t++) begin
            exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
        end
    endtask

    always @(posedge CLK) begin
        #1;
        w_ready = rand_ready ? 1'($urandom) : 1'b1;
    end

    // compare process: check outputs, then advance the model over the coming edge
    always @(negedge CLK) begin
        if (mon_en) begin
            chk("blk_ready", 64'(blk_ready), 64'(!m_active && !flush && !RST));
            chk("w_valid", 64'(w_valid), 64'(m_active));
            chk("done", 64'(done), 64'(m_done));
            chk("job_cnt", 64'(job_cnt), 64'(m_cnt));
            if (m_active) begin
                chk("w_idx", 64'(w_idx), 64'(m_idx));
                chk("w_word", 64'(w_word), 64'(exp_w[m_idx]));
                chk("w_last", 64'(w_last), 64'(m_idx == N-1));
            end else begin
                chk("w_last_idle", 64'(w_last), 64'd0);
                if (m_zero) begin
                    chk("w_word_rst", 64'(w_word), 64'd0);
                    chk("w_idx_rst", 64'(w_idx), 64'd0);
                end
            end
            if (RST) begin
                m_active = 1'b0; m_done = 1'b0; m_cnt = '0; m_zero = 1'b1;
            end else if (flush) begin
                m_active = 1'b0; m_done = 1'b0;
            end else if (m_active && w_ready) begin
                cap[m_idx] = w_word;
                if (m_idx == N-1) begin
                    m_active = 1'b0; m_done = 1'b1; m_cnt = m_cnt + 1'b1;
                end else begin
                    m_idx++; m_done = 1'b0;
                end
            end else if (!m_active && blk_valid) begin
                build(blk_in);
                m_active = 1'b1; m_idx = 0; m_done = 1'b0; m_zero = 1'b0;
            end else begin
                m_done = 1'b0;
            end
        end
    end

    task automatic wait_accept(input string name);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge CLK);
            if (blk_ready && blk_valid) ok = 1;
        end
        if (!ok) timeout(name);
        @(posedge CLK); #1;
    endtask

    task automatic send_block(input logic [511:0] b, input string name);
        blk_in = b;
        blk_valid = 1'b1;
        wait_accept(name);
        blk_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge CLK);
            if (done) ok = 1;
        end
        if (!ok) timeout(name);
        @(posedge CLK); #1;
    endtask

    task automatic wait_idx(input int idx, input string name);
        bit ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge CLK);
            if (w_valid && w_idx == 6'(idx)) ok = 1;
        end
        if (!ok) timeout(name);
        @(posedge CLK); #1;
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    logic [511:0] abc, b1, b2;

    initial begin
        RST = 1'b1; flush = 1'b0; blk_valid = 1'b0; blk_in = '0;
        abc = {32'h61626380, 448'd0, 32'h00000018};
        @(posedge CLK);
        mon_en = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK); #1;

        // abc block, always ready
        send_block(abc, "abc_accept");
        wait_done("abc_done");
        chk("abc_w0", 64'(cap[0]), 64'h61626380);
        chk("abc_w14", 64'(cap[14]), 64'h0);
        chk("abc_w16", 64'(cap[16]), 64'h61626380);
`ifdef W15_CONST_EN
        chk("abc_w15", 64'(cap[15]), 64'h280);
        chk("abc_w17", 64'(cap[17]), 64'h01100000);
`else
        chk("abc_w15", 64'(cap[15]), 64'h18);
        chk("abc_w17", 64'(cap[17]), 64'h000F0000);
`endif
        chk("abc_jobcnt", 64'(job_cnt), 64'd1);

        // same block with backpressure
        rand_ready = 1'b1;
        send_block(abc, "abc2_accept");
        wait_done("abc2_done");
        chk("abc2_w16", 64'(cap[16]), 64'h61626380);
        chk("abc2_jobcnt", 64'(job_cnt), 64'd2);

        // flush at idx 20
        rand_ready = 1'b0;
        send_block(rand_blk(), "fl_accept");
        wait_idx(19, "fl_idx19");
        flush = 1'b1;
        @(posedge CLK); #1 flush = 1'b0;
        @(negedge CLK);
        chk("fl_valid", 64'(w_valid), 64'd0);
        chk("fl_jobcnt", 64'(job_cnt), 64'd2);
        @(posedge CLK); #1;
        b1 = rand_blk();
        send_block(b1, "fl2_accept");
        wait_done("fl2_done");
        chk("fl2_w0", 64'(cap[0]), 64'(b1[511:480]));
        chk("fl2_jobcnt", 64'(job_cnt), 64'd3);

        // two blocks back-to-back, blk_valid held high
        b1 = rand_blk(); b2 = rand_blk();
        blk_in = b1; blk_valid = 1'b1;
        wait_accept("b2b_first");
        blk_in = b2;
        begin
            bit ok = 0;
            for (int i = 0; i < 300 && !ok; i++) begin
                @(negedge CLK);
                if (blk_ready) ok = 1;
            end
            if (!ok) timeout("b2b_second");
            chk("b2b_in_done", 64'(done), 64'd1);
            @(posedge CLK); #1 blk_valid = 1'b0;
        end
        wait_done("b2b_done");
        chk("b2b_w0", 64'(cap[0]), 64'(b2[511:480]));
        chk("b2b_jobcnt", 64'(job_cnt), 64'd5);

        // reset mid-stream at idx 40
        send_block(rand_blk(), "rst_accept");
        wait_idx(39, "rst_idx39");
        RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_valid", 64'(w_valid), 64'd0);
        chk("rst_jobcnt", 64'(job_cnt), 64'd0);
        chk("rst_ready", 64'(blk_ready), 64'd1);
        @(posedge CLK); #1;

        // low 64 bits all ones
        b1 = {rand_blk()} | 512'hFFFFFFFF_FFFFFFFF;
        send_block(b1, "c_accept");
        wait_done("c_done");
`ifdef W15_CONST_EN
        chk("c_w14", 64'(cap[14]), 64'h0);
        chk("c_w15", 64'(cap[15]), 64'h280);
`else
        chk("c_w14", 64'(cap[14]), 64'hFFFFFFFF);
        chk("c_w15", 64'(cap[15]), 64'hFFFFFFFF);
`endif

        // random jobs with backpressure and occasional flush
        rand_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            int k;
            k = $urandom_range(0, 90);
            send_block(rand_blk(), "r_accept");
            if (k < 63) begin
                wait_idx(k, "r_idx");
                flush = 1'b1;
                @(posedge CLK); #1 flush = 1'b0;
            end else begin
                wait_done("r_done");
            end
        end
        repeat (3) @(posedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sha256_w_sched_iter_ctrl.md
Name: sha256_w_sched_iter_ctrl

Overview:
Iterative controller for the SHA-256 message-expander datapath: it accepts one 512-bit block (W0..W15) per job and streams the schedule words W0..W(NUM_WORDS-1) to a round core, one word per accepted handshake.
- Holds a 16-word sliding window and time-multiplexes a single sigma0/sigma1/adder expander across all expansion steps, instead of one pipeline stage per word.
- Sits between the block/nonce source and the compression round core of the double-SHA256 path.

Parameters:
NUM_WORDS, 64, number of schedule words emitted per job; legal range 16..64.
CNT_W, 16, width of the completed-job counter.

Ports:
CLK  input  1  system clock, all state updated on rising edge
RST  input  1  synchronous, active-high reset
flush  input  1  synchronous abort of current job
blk_valid  input  1  source offers a block
blk_ready  output  1  controller accepts block this cycle
blk_in  input  512  W0 in [511:480] ... W15 in [31:0]
w_valid  output  1  schedule word valid
w_ready  input  1  round core accepts word
w_word  output  32  current schedule word W[t]
w_idx  output  6  index t of w_word
w_last  output  1  high when t == NUM_WORDS-1
done  output  1  one-cycle pulse after last word handshake
job_cnt  output  CNT_W  completed jobs, wraps

Behaviour:
- Reset (RST=1 at clock edge): state IDLE.
  - w_valid=0, w_word=0, w_idx=0, w_last=0, done=0, job_cnt=0, window cleared.
  - blk_ready=0 while RST is high.
- States: IDLE, STREAM.
  - blk_ready = (state==IDLE) && !flush && !RST.
- IDLE:
  - On blk_valid && blk_ready: load window[0..15] = W0..W15, t=0, go to STREAM.
  - Latency: W0 appears on w_word with w_valid=1 the cycle after acceptance.
- STREAM:
  - w_word = window[0], w_idx = t, w_valid = 1.
  - w_word, w_idx and w_last are held stable while w_valid && !w_ready.
- On w_valid && w_ready with t < NUM_WORDS-1:
  - Shift the window down one slot: window[i] <= window[i+1].
  - window[15] <= s1(window[14]) + window[9] + s0(window[1]) + window[0], mod 2^32. This is W[t+16].
  - Computation is suppressed (window[15] written with 0) when t+16 >= NUM_WORDS.
  - t <= t+1.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3; s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- On the handshake with t == NUM_WORDS-1 (w_last=1):
  - Go to IDLE, w_valid <= 0.
  - Next cycle: done=1 for one cycle and job_cnt increments; 2^CNT_W-1 wraps to 0.
- Back-to-back jobs: one idle bubble is mandatory. blk_ready rises in the cycle done pulses.
- flush (priority over all handshakes):
  - Next cycle: state IDLE, w_valid=0.
  - No done pulse, job_cnt unchanged.
  - A block offered in the same cycle as flush is not accepted.
- Reset mid-job: identical to power-on reset; no done pulse.
- blk_valid while in STREAM is ignored (blk_ready=0).
- w_ready is a don't-care while w_valid=0.

Optional Feature:
W15_CONST_EN
- Defined: at block load, window[14] is forced to 32'h00000000 and window[15] to 32'h00000280, regardless of blk_in[63:0]. This is the fixed length padding for the 640-bit second block in double SHA256. s0 applied to this constant is precomputed as a constant (no logic).
- Not defined: all 16 words are taken from blk_in.

Test Plan:
- Reset then "abc" padded block (W0=61626380, W1..W14=0, W15=00000018), w_ready=1 -> W0..W15 echoed in order; W16=61626380, W17=000F0000; w_last at idx 63; done pulse one cycle later; job_cnt=1.
- Same block with w_ready toggled 1/0 pseudo-randomly -> identical 64-word sequence; w_word/w_idx never change while w_valid&&!w_ready; each word exactly once.
- flush asserted while w_idx=20 -> w_valid=0 next cycle, no done, job_cnt unchanged; next block restarts at w_idx=0 with its correct W0.
- Two blocks offered continuously with blk_valid=1 -> second accepted exactly one cycle after the last word handshake of the first (in the done cycle); job_cnt=2.
- RST pulsed during STREAM at idx 40 -> all outputs return to reset values next cycle; blk_ready=1 once RST is low.
- With W15_CONST_EN defined, blk_in[63:0]=FFFFFFFF_FFFFFFFF -> emitted W14=00000000, W15=00000280; W16..W63 match a software model using the forced values.
